// File: rtl/pc_redirect_unit_pkg.sv
// ==========================================================================
// pc_redirect_unit_pkg : shared opcodes, FSM states and target helpers
// Rev 1.0
// ==========================================================================
`default_nettype none

package pc_redirect_unit_pkg;

  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;
  localparam logic [5:0]  OP_J   = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          CNT_W            = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Region bits come from the sequential PC, so a jump in the last slot
  // of a 256 MB region lands in the next region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
// ==========================================================================
// pc_redirect_unit_if : ID-stage controls in, fetch PC / flush / halt out
// Rev 1.0
// ==========================================================================
`default_nettype none

interface pc_redirect_unit_if;
  import pc_redirect_unit_pkg::*;

  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        branch;
  logic        jump;
  logic        ecall;
  logic        beq;
  logic        bne;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic        flush_if;
  logic        halted;

  modport master (
    output stall, id_valid, id_pc, id_instr, branch, jump, ecall, beq, bne,
           rs_val, rt_val,
    input  pc, flush_if, halted
  );

  modport slave (
    input  stall, id_valid, id_pc, id_instr, branch, jump, ecall, beq, bne,
           rs_val, rt_val,
    output pc, flush_if, halted
  );

endinterface

`default_nettype wire

// File: rtl/pc_redirect_unit_branch_target_calc.sv
// ==========================================================================
// branch_target_calc : combinational BEQ/BNE/J resolution and target
// Rev 1.0
// ==========================================================================
`default_nettype none

module branch_target_calc
  import pc_redirect_unit_pkg::*;
(
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        branch_i,
  input  logic        jump_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] pc_plus4;
  logic        operands_eq;
  logic        br_taken;
  logic        unused_opcode;

  assign pc_plus4    = id_pc_i + 32'd4;
  assign operands_eq = (rs_val_i == rt_val_i);

  // A branch with neither compare selected never redirects.
  assign br_taken = branch_i && ((beq_i && operands_eq) || (bne_i && !operands_eq));

  assign taken_o  = jump_i || br_taken;
  assign target_o = jump_i ? jump_target(pc_plus4, id_instr_i[25:0])
                           : pc_plus4 + branch_offset(id_instr_i[15:0]);

  assign unused_opcode = ^id_instr_i[31:26];

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ==========================================================================
// pc_redirect_unit : fetch PC owner; redirects on branch/jump, drains on ecall
// Rev 1.0
// ==========================================================================
`default_nettype none

module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_redirect_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;

  logic             resolve;
  logic             taken;
  logic [31:0]      target;
  logic             redirect;

  branch_target_calc u_target (
    .id_pc_i    (bus.id_pc),
    .id_instr_i (bus.id_instr),
    .rs_val_i   (bus.rs_val),
    .rt_val_i   (bus.rt_val),
    .beq_i      (bus.beq),
    .bne_i      (bus.bne),
    .branch_i   (bus.branch),
    .jump_i     (bus.jump),
    .taken_o    (taken),
    .target_o   (target)
  );

  assign resolve  = bus.id_valid && !bus.stall && (state_q == RUN);
  assign redirect = resolve && !bus.ecall && taken;

  // A stall suppresses the kill in every state; the frozen IF slot is
  // simply re-evaluated once the stall lifts.
  assign bus.flush_if = !bus.stall &&
                        ((state_q != RUN) || (resolve && (bus.ecall || taken)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else if (!bus.stall) begin
      unique case (state_q)
        RUN: begin
          if (resolve && bus.ecall) begin
            state_q <= DRAIN;
            cnt_q   <= DRAIN_LOAD;
          end else if (redirect) begin
            pc_q <= target;
          end else begin
            pc_q <= pc_q + 32'd4;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.halted = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ==========================================================================
// tb_pc_redirect_unit : vector table, directed corner cases, random vs model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DRAIN  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_unit_if bus();

  pc_redirect_unit #(.RESET_PC(RST_PC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: m_left counts unstalled edges still owed before halt.
  logic [31:0] m_pc;
  logic        m_halted;
  int          m_left;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] id_pc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        beq;
    logic        bne;
    logic        branch;
    logic        jump;
    logic        exp_flush;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ipc, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt, input logic bq,
                       input logic bn, input logic br, input logic jp, input logic ec,
                       input logic st);
    bus.id_valid = v;  bus.id_pc  = ipc; bus.id_instr = ins;
    bus.rs_val   = rs; bus.rt_val = rt;  bus.beq      = bq;
    bus.bne      = bn; bus.branch = br;  bus.jump     = jp;
    bus.ecall    = ec; bus.stall  = st;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input string tag, input logic exp_flush,
                      input logic [31:0] exp_pc, input logic exp_halted);
    @(negedge clk);
    chk({tag, "_flush"}, {31'b0, bus.flush_if}, {31'b0, exp_flush});
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_halted"}, {31'b0, bus.halted}, {31'b0, exp_halted});
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_flush", {31'b0, bus.flush_if}, 32'd0);
    m_pc = RST_PC; m_halted = 1'b0; m_left = -1;
  endtask

  function automatic void model(output logic f, output logic [31:0] np,
                                output logic nh, output int nl);
    logic        running;
    logic        tk;
    logic [31:0] seq;
    running = (m_left < 0) && !m_halted;
    seq     = bus.id_pc + 32'd4;
    tk      = bus.branch && ((bus.beq && bus.rs_val == bus.rt_val) ||
                             (bus.bne && bus.rs_val != bus.rt_val));
    np = m_pc; nh = m_halted; nl = m_left; f = 1'b0;
    if (bus.stall) return;
    if (!running) begin
      f = 1'b1;
      if (m_left > 0) begin
        nl = m_left - 1;
        if (nl == 0) begin nh = 1'b1; nl = -1; end
      end
      return;
    end
    if (bus.id_valid && bus.ecall) begin
      f  = 1'b1;
      nl = DRAIN;
    end else if (bus.id_valid && bus.jump) begin
      f  = 1'b1;
      np = (seq & 32'hF000_0000) | ((bus.id_instr & 32'h03FF_FFFF) * 4);
    end else if (bus.id_valid && tk) begin
      f  = 1'b1;
      np = seq + 32'(int'($signed(bus.id_instr[15:0])) * 4);
    end else begin
      np = m_pc + 32'd4;
    end
  endfunction

  task automatic rand_cycle();
    logic        f;
    logic        nh;
    logic [31:0] np;
    int          nl;
    drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
          32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
    model(f, np, nh, nl);
    tick("rnd", f, np, nh);
    m_pc = np; m_halted = nh; m_left = nl;
  endtask

  initial begin
    vt[0] = '{"beq_taken",   1'b1, 32'h0000_0040, 32'h1000_0003, 32'd5, 32'd5,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0050};
    vt[1] = '{"bne_not",     1'b1, 32'h0000_0040, 32'h1400_FFFE, 32'd5, 32'd5,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{"bne_taken",   1'b1, 32'h0000_0040, 32'h1400_FFFE, 32'd5, 32'd6,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_003C};
    vt[3] = '{"jump",        1'b1, 32'h1000_0000, 32'h0800_0100, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0400};
    vt[4] = '{"br_nocmp",    1'b1, 32'h0000_0080, 32'h1000_0005, 32'd7, 32'd7,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[5] = '{"jump_region", 1'b1, 32'h0FFF_FFFC, 32'h0800_0003, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_000C};
    vt[6] = '{"beq_wrap",    1'b1, 32'hFFFF_FFF8, 32'h1000_0001, 32'd9, 32'd9,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vt[7] = '{"jump_over_br", 1'b1, 32'h0000_0100, 32'h0800_0080, 32'd1, 32'd1,
              1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200};
    vt[8] = '{"jump_bubble", 1'b0, 32'h0000_0000, 32'h0800_0100, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

    do_reset();

    for (int i = 1; i <= 4; i++) begin
      tick("seq", 1'b0, 32'(i * 4), 1'b0);
      m_pc = 32'(i * 4);
    end

    foreach (vt[i]) begin
      logic [31:0] nxt;
      drive(vt[i].valid, vt[i].id_pc, vt[i].instr, vt[i].rs, vt[i].rt, vt[i].beq,
            vt[i].bne, vt[i].branch, vt[i].jump, 1'b0, 1'b0);
      nxt = vt[i].exp_flush ? vt[i].exp_target : m_pc + 32'd4;
      tick(vt[i].name, vt[i].exp_flush, nxt, 1'b0);
      m_pc = nxt;
    end

    // Stalled taken branch: nothing moves until the stall lifts.
    drive(1'b1, 32'h40, 32'h1000_0003, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick("stall0", 1'b0, m_pc, 1'b0);
    tick("stall1", 1'b0, m_pc, 1'b0);
    bus.stall = 1'b0;
    tick("unstall", 1'b1, 32'h50, 1'b0);
    m_pc = 32'h50;

    // Ecall beats a simultaneous jump; halted appears after DRAIN+1 edges.
    drive(1'b1, 32'h200, 32'h0800_0010, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick("ecall", 1'b1, m_pc, 1'b0);
    drive(1'b1, 32'h300, 32'h0800_0020, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= DRAIN + 1; k++) tick("drain", 1'b1, m_pc, k == DRAIN + 1);
    for (int k = 0; k < 3; k++) tick("halt", 1'b1, m_pc, 1'b1);

    do_reset();
    drive(1'b1, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("ecall2", 1'b1, RST_PC, 1'b0);
    idle();
    tick("drain2", 1'b1, RST_PC, 1'b0);
    do_reset();
    tick("post_rst", 1'b0, RST_PC + 32'd4, 1'b0);
    m_pc = RST_PC + 32'd4;

    for (int n = 0; n < 600; n++) begin
      if ((m_halted || m_left > 0) && $urandom_range(0, 7) == 0) do_reset();
      rand_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
